// File: rtl/video_fetch_ctrl.sv
// Purpose: framebuffer fetch sequencer; issues one BURST-pixel read at a time and streams returned pixels into the pixel FIFO.
// Latency: returned beat to fifo_wr is one cycle; a new request is raised one cycle after the FIFO has room for a whole burst.
// Backpressure: requests are held until rd_ack and wait in CHECK while the FIFO lacks BURST free words; one burst outstanding.
module video_fetch_ctrl #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          BURST      = 16,
  parameter int          FIFO_DEPTH = 256,
  parameter logic [31:0] BASE       = 32'h0
) (
  input  logic                          pixel_clk,
  input  logic                          pixel_rst_n,
  input  logic                          frame_start,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rd_req,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_ack,
  input  logic                          rd_valid,
  input  logic [23:0]                   rd_data,
  output logic                          fifo_wr,
  output logic [23:0]                   fifo_wdata,
  output logic                          fifo_clr,
  output logic                          frame_err
);

  localparam int          NBURSTS    = HDISP * VDISP / BURST;
  localparam int          CW         = $clog2(NBURSTS + 1);
  localparam int          BW         = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_BURST = CW'(NBURSTS);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST - 1);
  localparam logic [31:0] ADDR_STEP  = 32'(BURST * 4);
  localparam logic [31:0] DEPTH_W    = 32'(FIFO_DEPTH);
  localparam logic [31:0] BURST_W    = 32'(BURST);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   burst_cnt;
  logic [BW-1:0]   beat_cnt;
  logic            abort;
  logic            have_space;
  logic            drop_beat;
  logic [CW-1:0]   burst_nxt;

  // Room for a whole burst: FIFO_DEPTH - level >= BURST, rearranged to avoid underflow.
  assign have_space = (32'(fifo_level) + BURST_W) <= DEPTH_W;
  // A frame_start arriving mid-burst already poisons the beat landing in the same cycle.
  assign drop_beat  = abort | frame_start;
  assign burst_nxt  = burst_cnt + CW'(1);

  // Fetch FSM with all outputs registered; restart = flush FIFO, rewind address, back to CHECK.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state      <= IDLE;
      rd_req     <= 1'b0;
      rd_addr    <= BASE;
      fifo_wr    <= 1'b0;
      fifo_wdata <= '0;
      fifo_clr   <= 1'b0;
      frame_err  <= 1'b0;
      burst_cnt  <= '0;
      beat_cnt   <= '0;
      abort      <= 1'b0;
    end else begin
      fifo_wr   <= 1'b0;
      fifo_clr  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (frame_start) begin
            fifo_clr  <= 1'b1;
            rd_addr   <= BASE;
            burst_cnt <= '0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (frame_start) begin
            frame_err <= 1'b1;
            fifo_clr  <= 1'b1;
            rd_addr   <= BASE;
            burst_cnt <= '0;
          end else if (have_space) begin
            rd_req <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (frame_start) begin
            frame_err <= 1'b1;
            abort     <= 1'b1;
          end
          // The handshake always completes, even when aborting, so the memory side stays consistent.
          if (rd_ack) begin
            rd_req   <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (frame_start) begin
            frame_err <= 1'b1;
            abort     <= 1'b1;
          end
          if (rd_valid) begin
            if (!drop_beat) begin
              fifo_wr    <= 1'b1;
              fifo_wdata <= rd_data;
            end
            beat_cnt <= beat_cnt + BW'(1);
            if (beat_cnt == LAST_BEAT) begin
              if (drop_beat) begin
                abort     <= 1'b0;
                fifo_clr  <= 1'b1;
                rd_addr   <= BASE;
                burst_cnt <= '0;
                state     <= CHECK;
              end else begin
                rd_addr   <= rd_addr + ADDR_STEP;
                burst_cnt <= burst_nxt;
                state     <= (burst_nxt < LAST_BURST) ? CHECK : DONE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_fetch_ctrl.sv
// Purpose: directed bench for video_fetch_ctrl using a reduced 64x8 frame (32 bursts of 16 pixels).
// Latency: inputs are driven 1 ns after the rising edge and outputs are sampled at that point.
// Backpressure: the bench plays the memory and FIFO-level side, including a 3-cycle ack memory model.
module tb_video_fetch_ctrl;

  localparam int HD = 64;
  localparam int VD = 8;
  localparam int BU = 16;
  localparam int FD = 256;
  localparam int NB = HD * VD / BU;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n;
  logic        frame_start;
  logic [8:0]  fifo_level;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        fifo_wr;
  logic [23:0] fifo_wdata;
  logic        fifo_clr;
  logic        frame_err;

  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  int          req_cyc = 0;
  longint      wsum = 0;
  logic [31:0] last_acc_addr = '0;

  video_fetch_ctrl #(.HDISP(HD), .VDISP(VD), .BURST(BU), .FIFO_DEPTH(FD), .BASE(32'h0)) dut (
    .pixel_clk   (pixel_clk),
    .pixel_rst_n (pixel_rst_n),
    .frame_start (frame_start),
    .fifo_level  (fifo_level),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .fifo_wr     (fifo_wr),
    .fifo_wdata  (fifo_wdata),
    .fifo_clr    (fifo_clr),
    .frame_err   (frame_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Passive monitor on the falling edge: FIFO writes, pixel checksum, accepted requests.
  always @(negedge pixel_clk) begin
    if (fifo_wr) begin
      wr_cnt <= wr_cnt + 1;
      wsum   <= wsum + longint'(fifo_wdata);
    end
    if (rd_req) begin
      req_cyc <= req_cyc + 1;
      if (rd_ack) begin
        acc_cnt       <= acc_cnt + 1;
        last_acc_addr <= rd_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    pixel_rst_n = 1'b0;
    tick();
    pixel_rst_n = 1'b1;
    fifo_level  = '0;
    tick();
  endtask

  // Accept the pending request immediately, then deliver n beats starting at d0.
  task automatic ack_beats(input int n, input logic [23:0] d0);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1;
      rd_data  = d0 + 24'(i);
      tick();
    end
    rd_valid = 1'b0;
  endtask

  // Memory model: ack 3 cycles after rd_req rises, then 16 beats of incrementing pixel data.
  task automatic run_mem(input int nbursts);
    logic [23:0] pix;
    int t;
    pix = '0;
    for (int b = 0; b < nbursts; b++) begin
      t = 0;
      while (!rd_req && t < 200) begin
        tick();
        t++;
      end
      if (!rd_req) begin
        chk("mem_req_wait", 32'(rd_req), 32'd1);
        return;
      end
      repeat (3) tick();
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      for (int i = 0; i < BU; i++) begin
        rd_valid = 1'b1;
        rd_data  = pix;
        pix      = pix + 24'd1;
        tick();
      end
      rd_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0, r0, bad, seen_req, seen_wr;
    longint s0;
    pixel_rst_n = 1'b0;
    frame_start = 1'b0;
    fifo_level  = '0;
    rd_ack      = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    #12;
    chk("rst_ctl",   32'({rd_req, fifo_wr, fifo_clr, frame_err}), 32'd0);
    chk("rst_addr",  rd_addr, 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    tick();
    pixel_rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_noreq", 32'(rd_req), 32'd0);

    // First frame: flush pulse, first request at BASE, immediate ack.
    pulse_frame();
    chk("clr_pulse", 32'(fifo_clr), 32'd1);
    chk("clr_noreq", 32'(rd_req), 32'd0);
    tick();
    chk("clr_once",  32'(fifo_clr), 32'd0);
    chk("req0",      32'(rd_req), 32'd1);
    chk("req0_addr", rd_addr, 32'd0);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    chk("ack_drop", 32'(rd_req), 32'd0);
    bad = 0;
    for (int i = 0; i < BU; i++) begin
      rd_valid = 1'b1;
      rd_data  = 24'h100 + 24'(i);
      tick();
      if (fifo_wr !== 1'b1 || fifo_wdata !== 24'h100 + 24'(i)) bad++;
    end
    rd_valid = 1'b0;
    chk("burst0_beats", 32'(bad), 32'd0);
    tick();
    chk("req1",      32'(rd_req), 32'd1);
    chk("req1_addr", rd_addr, 32'd64);

    // FIFO threshold: 241 words leaves 15 free, 240 leaves exactly one burst; stray beats in CHECK ignored.
    fifo_level = 9'd241;
    ack_beats(BU, 24'h200);
    seen_req = 0;
    seen_wr  = 0;
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1'b1;
      rd_data  = 24'hABCDEF;
      tick();
      if (rd_req) seen_req++;
      if (fifo_wr) seen_wr++;
    end
    rd_valid = 1'b0;
    chk("full_noreq", 32'(seen_req), 32'd0);
    chk("check_nowr", 32'(seen_wr), 32'd0);
    fifo_level = 9'd240;
    tick();
    chk("space_req",  32'(rd_req), 32'd1);
    chk("space_addr", rd_addr, 32'd128);

    // Full frame through the 3-cycle memory model.
    do_reset();
    w0 = wr_cnt;
    a0 = acc_cnt;
    s0 = wsum;
    pulse_frame();
    run_mem(NB);
    r0 = req_cyc;
    repeat (40) tick();
    chk("frame_reqs",  32'(acc_cnt - a0), 32'(NB));
    chk("frame_wrs",   32'(wr_cnt - w0), 32'(HD * VD));
    chk("frame_sum",   32'(wsum - s0), 32'd130816);
    chk("frame_last",  last_acc_addr, 32'((NB - 1) * BU * 4));
    chk("done_noreq",  32'(req_cyc - r0), 32'd0);
    chk("done_addr",   rd_addr, 32'(NB * BU * 4));

    // Abort: frame_start after 5 beats of the second burst.
    do_reset();
    pulse_frame();
    tick();
    ack_beats(BU, 24'h300);
    tick();
    chk("abort_pre_addr", rd_addr, 32'd64);
    ack_beats(5, 24'h500);
    pulse_frame();
    chk("abort_err", 32'(frame_err), 32'd1);
    w0 = wr_cnt;
    for (int i = 0; i < BU - 5; i++) begin
      rd_valid = 1'b1;
      rd_data  = 24'h505 + 24'(i);
      tick();
      if (i == 0) chk("abort_err_once", 32'(frame_err), 32'd0);
    end
    rd_valid = 1'b0;
    chk("abort_clr",  32'(fifo_clr), 32'd1);
    chk("abort_addr", rd_addr, 32'd0);
    tick();
    chk("abort_drop",     32'(wr_cnt - w0), 32'd0);
    chk("abort_req",      32'(rd_req), 32'd1);
    chk("abort_req_addr", rd_addr, 32'd0);
    ack_beats(1, 24'h777);
    chk("resume_wr",   32'(fifo_wr), 32'd1);
    chk("resume_data", 32'(fifo_wdata), 32'h777);

    // Reset in the middle of a burst.
    do_reset();
    pulse_frame();
    tick();
    ack_beats(3, 24'h0F0F0F);
    chk("pre_rst_wr", 32'(fifo_wr), 32'd1);
    #2;
    pixel_rst_n = 1'b0;
    #1;
    chk("arst_ctl",   32'({rd_req, fifo_wr, fifo_clr, frame_err}), 32'd0);
    chk("arst_wdata", 32'(fifo_wdata), 32'd0);
    chk("arst_addr",  rd_addr, 32'd0);
    #3;
    pixel_rst_n = 1'b1;
    r0 = req_cyc;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      rd_valid = 1'b1;
      rd_ack   = i[0];
      rd_data  = 24'h123456;
      tick();
    end
    rd_valid = 1'b0;
    rd_ack   = 1'b0;
    tick();
    chk("post_rst_noreq", 32'(req_cyc - r0), 32'd0);
    chk("post_rst_nowr",  32'(wr_cnt - w0), 32'd0);
    pulse_frame();
    tick();
    chk("post_rst_req",  32'(rd_req), 32'd1);
    chk("post_rst_addr", rd_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
